i2c_slave: RTL and testbench

- I2C target/responder for the same single-master bus that the i2c master controller drives.
- Oversamples scl/sda with the system clock and detects START, STOP and repeated START.
- Matches a 7-bit address and ACKs it, then either receives write bytes or returns read bytes.
- sda uses a split open-drain interface: sda_in plus a pull-low enable, matching the master's split sda/sda_in scheme.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_line_sync.sv | 55 +++++
 rtl/i2c_slave.sv | 192 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the I2C target.
package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam int   I2C_DATA_W = 8;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes one bus line into clk and reports its level and
// single-cycle rise/fall strobes. With I2C_SLAVE_GLITCH_FILTER_EN defined, a
// level change is accepted only after three consecutive agreeing samples.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   prev_q;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchronizer chain; idles at the bus-released level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] hist_q;

    // Sample history and last accepted level (doubles as edge reference).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '1;
            prev_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_out};
            prev_q <= level;
        end
    end

    assign level = (sync_out == hist_q[0] && sync_out == hist_q[1]) ? sync_out : prev_q;
`else
    // Previous level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_q <= 1'b1;
        else        prev_q <= level;
    end

    assign level = sync_out;
`endif

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with 7-bit address match, write receive and read
// return over a split open-drain sda. Optional input glitch filter is enabled
// by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h52,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_DATA_W-1:0] tx_data,
    output logic                  tx_load,
    output logic                  rw_bit,
    output logic                  busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start, stop;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .reset(reset), .din(scl_in),
        .level(scl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .reset(reset), .din(sda_in),
        .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    assign start = sda_fall & scl;
    assign stop  = sda_rise & scl;

    state_t                  state, state_d;
    logic [2:0]              bit_cnt, bit_cnt_d;
    logic [I2C_DATA_W-1:0]   shift, shift_d;
    logic                    full, full_d;
    logic                    ack, ack_d;
    logic                    oe_d, rx_valid_d, tx_load_d, rw_d, busy_d;
    logic [I2C_DATA_W-1:0]   rx_data_d;

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            full     <= 1'b0;
            ack      <= I2C_NACK;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            rw_bit   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            shift    <= shift_d;
            full     <= full_d;
            ack      <= ack_d;
            sda_oe   <= oe_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
            tx_load  <= tx_load_d;
            rw_bit   <= rw_d;
            busy     <= busy_d;
        end
    end

    // Next-state and output logic; START/STOP override every state.
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        shift_d    = shift;
        full_d     = full;
        ack_d      = ack;
        oe_d       = sda_oe;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        rw_d       = rw_bit;
        busy_d     = busy;

        if (start) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            full_d    = 1'b0;
            oe_d      = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            full_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift[I2C_DATA_W-2:0], sda};
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) full_d = 1'b1;
                    end else if (scl_fall && full) begin
                        full_d = 1'b0;
                        if (shift[I2C_DATA_W-1:1] == SLAVE_ADDR) begin
                            oe_d    = 1'b1;
                            rw_d    = shift[0];
                            busy_d  = 1'b1;
                            state_d = ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_bit) begin
                            tx_load_d = 1'b1;
                            shift_d   = tx_data;
                            oe_d      = ~tx_data[I2C_DATA_W-1];
                            state_d   = RD_DATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift[I2C_DATA_W-2:0], sda};
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            full_d     = 1'b1;
                            rx_data_d  = {shift[I2C_DATA_W-2:0], sda};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && full) begin
                        full_d  = 1'b0;
                        oe_d    = 1'b1;
                        state_d = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        state_d = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            ack_d     = I2C_NACK;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d   = {shift[I2C_DATA_W-2:0], 1'b0};
                            oe_d      = ~shift[I2C_DATA_W-2];
                            bit_cnt_d = bit_cnt + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        ack_d = sda;
                    end else if (scl_fall) begin
                        if (ack == I2C_ACK) begin
                            tx_load_d = 1'b1;
                            shift_d   = tx_data;
                            oe_d      = ~tx_data[I2C_DATA_W-1];
                            state_d   = RD_DATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: oe_d = 1'b0;
                default:   state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bus-level master model with a scoreboard for rx/tx events.
module tb_i2c_slave;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       rw_bit;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int oe_cnt = 0;
    logic [7:0] exp_rx_q[$];
    bit         exp_tx_q[$];

    assign sda_in = sda_m & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h52), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_in),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load), .rw_bit(rw_bit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT reports an event.
    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (rx_valid) begin
            check("rx_valid_expected", 32'(exp_rx_q.size() != 0), 32'd1);
            if (exp_rx_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
        end
        if (tx_load) begin
            check("tx_load_expected", 32'(exp_tx_q.size() != 0), 32'd1);
            if (exp_tx_q.size() != 0) void'(exp_tx_q.pop_front());
        end
    end

    task automatic quarter();
        repeat (8) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b0; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b1; quarter();
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;    quarter();
        scl_m = 1'b1; quarter();
        s = sda_in;   quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string name);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        check(name, 32'(s), 32'(exp_ack));
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic mack,
                             input logic [7:0] next_tx, input string name);
        logic [7:0] got;
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            got[i] = s;
        end
        check(name, 32'(got), 32'(exp));
        tx_data = next_tx;
        clock_bit(mack, s);
        check({name, "_ack_slot"}, 32'(s), 32'(mack));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s;
        int oe_base;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_sda_oe",   32'(sda_oe),   32'd0);
        check("rst_rx_data",  32'(rx_data),  32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_load",  32'(tx_load),  32'd0);
        check("rst_rw_bit",   32'(rw_bit),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_state",    32'(dut.state), 32'(IDLE));
        reset = 1'b1;
        quarter();

        // Write 0xAA to 0x52
        exp_rx_q.push_back(8'hAA);
        bus_start();
        write_byte(8'hA4, 1'b0, "wr_addr_ack");
        check("wr_busy", 32'(busy), 32'd1);
        write_byte(8'hAA, 1'b0, "wr_data_ack");
        bus_stop();
        quarter();
        check("wr_busy_after_stop", 32'(busy), 32'd0);
        check("wr_state_idle", 32'(dut.state), 32'(IDLE));
        check("wr_rx_outstanding", 32'(exp_rx_q.size()), 32'd0);

        // Address mismatch 0x4C
        oe_base = oe_cnt;
        bus_start();
        write_byte(8'h98, 1'b1, "mm_addr_nack");
        write_byte(8'h33, 1'b1, "mm_data_nack");
        check("mm_state", 32'(dut.state), 32'(WAIT_STOP));
        check("mm_busy", 32'(busy), 32'd0);
        bus_stop();
        quarter();
        check("mm_oe_never", 32'(oe_cnt - oe_base), 32'd0);
        check("mm_state_idle", 32'(dut.state), 32'(IDLE));

        // Single read of 0x70, master NACK
        tx_data = 8'h70;
        exp_tx_q.push_back(1'b1);
        bus_start();
        write_byte(8'hA5, 1'b0, "rd_addr_ack");
        check("rd_rw_bit", 32'(rw_bit), 32'd1);
        read_byte(8'h70, 1'b1, 8'h70, "rd_byte");
        check("rd_state", 32'(dut.state), 32'(WAIT_STOP));
        bus_stop();
        quarter();
        check("rd_tx_outstanding", 32'(exp_tx_q.size()), 32'd0);

        // Two-byte read: 0x09 (ACK) then 0xF0 (NACK)
        tx_data = 8'h09;
        exp_tx_q.push_back(1'b1);
        exp_tx_q.push_back(1'b1);
        bus_start();
        write_byte(8'hA5, 1'b0, "mr_addr_ack");
        read_byte(8'h09, 1'b0, 8'hF0, "mr_byte0");
        read_byte(8'hF0, 1'b1, 8'hF0, "mr_byte1");
        bus_stop();
        quarter();
        check("mr_tx_outstanding", 32'(exp_tx_q.size()), 32'd0);

        // Write 0x11, repeated START, read 0xC3
        exp_rx_q.push_back(8'h11);
        exp_tx_q.push_back(1'b1);
        tx_data = 8'hC3;
        bus_start();
        write_byte(8'hA4, 1'b0, "rs_wr_addr_ack");
        write_byte(8'h11, 1'b0, "rs_wr_data_ack");
        check("rs_rx_data", 32'(rx_data), 32'h11);
        bus_start();
        write_byte(8'hA5, 1'b0, "rs_rd_addr_ack");
        check("rs_rw_bit", 32'(rw_bit), 32'd1);
        check("rs_busy", 32'(busy), 32'd1);
        read_byte(8'hC3, 1'b1, 8'hC3, "rs_rd_byte");
        bus_stop();
        quarter();
        check("rs_busy_after_stop", 32'(busy), 32'd0);
        check("rs_rx_outstanding", 32'(exp_rx_q.size()), 32'd0);
        check("rs_tx_outstanding", 32'(exp_tx_q.size()), 32'd0);

        // Reset during bit 4 of a read byte (0x70: bit 4 drives a 0)
        tx_data = 8'h70;
        exp_tx_q.push_back(1'b1);
        bus_start();
        write_byte(8'hA5, 1'b0, "ra_addr_ack");
        for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        check("ra_oe_before_reset", 32'(sda_oe), 32'd1);
        reset = 1'b0;
        #1;
        check("ra_oe_same_cycle", 32'(sda_oe), 32'd0);
        @(negedge clk);
        check("ra_busy",   32'(busy),    32'd0);
        check("ra_rw_bit", 32'(rw_bit),  32'd0);
        check("ra_rx_data", 32'(rx_data), 32'h00);
        check("ra_state",  32'(dut.state), 32'(IDLE));
        quarter();
        reset = 1'b1;
        quarter();
        check("ra_tx_outstanding", 32'(exp_tx_q.size()), 32'd0);

        // STOP after 5 data bits: partial byte discarded
        bus_start();
        write_byte(8'hA4, 1'b0, "sa_addr_ack");
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        bus_stop();
        quarter();
        check("sa_state", 32'(dut.state), 32'(IDLE));
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_rx_data_kept", 32'(rx_data), 32'h00);
        check("sa_rx_outstanding", 32'(exp_rx_q.size()), 32'd0);

        quarter();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
